// File: rtl/decode_stage_if.sv
// Handshake and data bundle between decode_stage and its neighbours:
// upstream fetch, writeback and the execute ALU.
interface decode_stage_if #(
    parameter int XLEN   = 19,
    parameter int REG_AW = 3
);
    logic              instr_valid_i;
    logic [XLEN-1:0]   instr_i;
    logic              instr_ready_o;

    logic              wb_en_i;
    logic [REG_AW-1:0] wb_addr_i;
    logic [XLEN-1:0]   wb_data_i;

    logic              dec_valid_o;
    logic              dec_ready_i;
    logic [XLEN-1:0]   opr_a_o;
    logic [XLEN-1:0]   opr_b_o;
    logic [3:0]        op_sel_o;
    logic [REG_AW-1:0] rd_addr_o;
    logic              rd_we_o;

    // Decode stage side.
    modport slave (
        input  instr_valid_i, instr_i,
        output instr_ready_o,
        input  wb_en_i, wb_addr_i, wb_data_i,
        output dec_valid_o,
        input  dec_ready_i,
        output opr_a_o, opr_b_o, op_sel_o, rd_addr_o, rd_we_o
    );

    // Environment side: fetch, writeback and execute.
    modport master (
        output instr_valid_i, instr_i,
        input  instr_ready_o,
        output wb_en_i, wb_addr_i, wb_data_i,
        input  dec_valid_o,
        output dec_ready_i,
        input  opr_a_o, opr_b_o, op_sel_o, rd_addr_o, rd_we_o
    );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: register file with writeback bypass, busy-bit scoreboard for
// RAW/WAW stalls, and a registered valid/ready bundle towards execute.
module decode_stage #(
    parameter int XLEN     = 19,
    parameter int NUM_REGS = 8,
    parameter int REG_AW   = 3
) (
    input  logic          clk,
    input  logic          reset,
    decode_stage_if.slave bus
);

    logic [3:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              imm_sel;
    logic [4:0]        imm5;

    assign op      = bus.instr_i[18:15];
    assign rd      = bus.instr_i[14:12];
    assign rs1     = bus.instr_i[11:9];
    assign rs2     = bus.instr_i[8:6];
    assign imm_sel = bus.instr_i[5];
    assign imm5    = bus.instr_i[4:0];

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] busy_eff;
    logic                wb_fire;
    logic                hazard;
    logic                ready;
    logic                accept;
    logic [XLEN-1:0]     rd_a;
    logic [XLEN-1:0]     rd_b;

    // Writeback is ignored while reset is held.
    assign wb_fire = bus.wb_en_i && !reset;

    function automatic logic [XLEN-1:0] read_reg(input logic [REG_AW-1:0] src);
        if (src == '0)
            return '0;
        else if (wb_fire && bus.wb_addr_i == src)
            return bus.wb_data_i;
        else
            return regs[src];
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (wb_fire)
            clr_mask = NUM_REGS'(1) << bus.wb_addr_i;
        if (accept && rd != '0)
            set_mask = NUM_REGS'(1) << rd;
        busy_eff  = busy & ~clr_mask;
        busy_next = (busy_eff | set_mask) & ~NUM_REGS'(1);
    end

    // A register being released by writeback this cycle no longer blocks.
    assign hazard = busy_eff[rs1] || (busy_eff[rs2] && !imm_sel) || busy_eff[rd];
    assign ready  = !reset && !hazard && (!bus.dec_valid_o || bus.dec_ready_i);
    assign accept = bus.instr_valid_i && ready;
    assign bus.instr_ready_o = ready;

    assign rd_a = read_reg(rs1);
    assign rd_b = imm_sel ? {{(XLEN-5){imm5[4]}}, imm5} : read_reg(rs2);

    // NOTE: the register file is reset like any other state because reads of
    // a just-reset register must return zero, not stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (bus.wb_en_i && bus.wb_addr_i != '0) begin
            regs[bus.wb_addr_i] <= bus.wb_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset)
            busy <= '0;
        else
            busy <= busy_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.dec_valid_o <= 1'b0;
            bus.opr_a_o     <= '0;
            bus.opr_b_o     <= '0;
            bus.op_sel_o    <= '0;
            bus.rd_addr_o   <= '0;
            bus.rd_we_o     <= 1'b0;
        end else if (accept) begin
            bus.dec_valid_o <= 1'b1;
            bus.opr_a_o     <= rd_a;
            bus.opr_b_o     <= rd_b;
            bus.op_sel_o    <= op;
            bus.rd_addr_o   <= rd;
            bus.rd_we_o     <= (rd != '0);
        end else if (bus.dec_ready_i) begin
            // Bundle consumed with nothing new: drop valid, keep data.
            bus.dec_valid_o <= 1'b0;
        end
    end

endmodule
